// File: rtl/conv_window_reader.sv
// Sliding-window reader: pops a first-word-fall-through FIFO and presents
// WindowSize-sample windows per line over a valid/ready handshake.
// Optional stall statistics (StallCnt port) under CONV_READER_STATS_EN.
module conv_window_reader #(
  parameter int DataWidth  = 32,
  parameter int BufferSize = 16,
  parameter int WindowSize = 3,
  parameter int LineLength = 16
) (
  input  logic                            clk,
  input  logic                            aclr,
  input  logic                            Enable,
  input  logic [BufferSize-1:0]           ReadyM,
  input  logic [DataWidth-1:0]            FifoData,
  output logic                            Pop,
  output logic                            WinValid,
  input  logic                            WinReady,
  output logic [WindowSize*DataWidth-1:0] WinData,
`ifdef CONV_READER_STATS_EN
  output logic [15:0]                     StallCnt,
`endif
  output logic                            WinLast
);

  localparam int ColW  = (LineLength > 1) ? $clog2(LineLength) : 1;
  localparam int FillW = $clog2(WindowSize + 1);
  localparam int TapW  = WindowSize * DataWidth;

  localparam logic [ColW-1:0]  ColLast    = ColW'(LineLength - 1);
  localparam logic [ColW-1:0]  ColOne     = ColW'(1);
  localparam logic [FillW-1:0] FillFull   = FillW'(WindowSize);
  localparam logic [FillW-1:0] FillStream = FillW'(WindowSize - 1);
  localparam logic [FillW-1:0] FillOne    = FillW'(1);

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e            state_r, state_next_s;
  logic [FillW-1:0]  fill_cnt_r, fill_cnt_next_s, fill_inc_s;
  logic [ColW-1:0]   col_cnt_r, col_cnt_next_s;
  logic [TapW-1:0]   taps_r, taps_next_s;
  logic              win_valid_r, win_valid_next_s;
  logic              win_last_r, win_last_next_s;
  logic              not_empty_s, pop_s, emit_s, line_end_s;

  assign not_empty_s = |ReadyM;
  assign pop_s       = Enable & not_empty_s & (~win_valid_r | WinReady);
  assign fill_inc_s  = (fill_cnt_r == FillFull) ? FillFull : (fill_cnt_r + FillOne);
  assign line_end_s  = (col_cnt_r == ColLast);
  // Every pop taken in STREAM completes a window; FILL pops never do.
  assign emit_s      = (state_r == ST_STREAM);

  // Next-state and datapath update for the fill/stream controller.
  always_comb begin
    state_next_s     = state_r;
    fill_cnt_next_s  = fill_cnt_r;
    col_cnt_next_s   = col_cnt_r;
    taps_next_s      = taps_r;
    win_last_next_s  = win_last_r;
    win_valid_next_s = win_valid_r;

    case (state_r)
      ST_FILL: begin
        if (pop_s && !line_end_s && (fill_inc_s >= FillStream)) begin
          state_next_s = ST_STREAM;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_STREAM: begin
        if (pop_s && line_end_s) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      default: begin
        state_next_s = ST_FILL;
      end
    endcase

    if (pop_s) begin
      taps_next_s     = {taps_r[TapW-DataWidth-1:0], FifoData};
      win_last_next_s = line_end_s;
      // A line boundary abandons the fill so windows never straddle lines.
      if (line_end_s) begin
        col_cnt_next_s  = '0;
        fill_cnt_next_s = '0;
      end else begin
        col_cnt_next_s  = col_cnt_r + ColOne;
        fill_cnt_next_s = fill_inc_s;
      end
    end else begin
      taps_next_s = taps_r;
    end

    if (pop_s && emit_s) begin
      win_valid_next_s = 1'b1;
    end else if (WinReady) begin
      win_valid_next_s = 1'b0;
    end else begin
      win_valid_next_s = win_valid_r;
    end
  end

  // Controller and window registers.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_r     <= ST_FILL;
      fill_cnt_r  <= '0;
      col_cnt_r   <= '0;
      taps_r      <= '0;
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      fill_cnt_r  <= fill_cnt_next_s;
      col_cnt_r   <= col_cnt_next_s;
      taps_r      <= taps_next_s;
      win_valid_r <= win_valid_next_s;
      win_last_r  <= win_last_next_s;
    end
  end

`ifdef CONV_READER_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles a window waits on the consumer.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      stall_cnt_r <= 16'h0000;
    end else if (win_valid_r && !WinReady && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign StallCnt = stall_cnt_r;
`else
  // Stall statistics are not built in this configuration.
`endif

  assign Pop      = pop_s;
  assign WinValid = win_valid_r;
  assign WinData  = taps_r;
  assign WinLast  = win_last_r;

endmodule

// File: tb/tb_conv_window_reader.sv
// Self-checking bench for conv_window_reader: directed test-plan steps followed by
// randomized traffic, compared against a per-line sample-queue reference model.
module tb_conv_window_reader;

  localparam int DW = 32;
  localparam int BS = 16;
  localparam int WS = 3;
  localparam int LL = 16;
  localparam int TW = WS * DW;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          Enable = 1'b0;
  logic [BS-1:0] ReadyM = '0;
  logic [DW-1:0] FifoData = '0;
  logic          Pop;
  logic          WinValid;
  logic          WinReady = 1'b0;
  logic [TW-1:0] WinData;
  logic          WinLast;
`ifdef CONV_READER_STATS_EN
  logic [15:0]   StallCnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] line_q[$];
  logic [DW-1:0] next_sample = '0;
  int            col = 0;
  bit            want_valid = 1'b0;
  bit            want_last = 1'b0;
  logic [TW-1:0] want_data = '0;
  logic [15:0]   want_stall = '0;

  conv_window_reader #(
    .DataWidth(DW), .BufferSize(BS), .WindowSize(WS), .LineLength(LL)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .Enable(Enable),
    .ReadyM(ReadyM),
    .FifoData(FifoData),
    .Pop(Pop),
    .WinValid(WinValid),
    .WinReady(WinReady),
    .WinData(WinData),
`ifdef CONV_READER_STATS_EN
    .StallCnt(StallCnt),
`endif
    .WinLast(WinLast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [TW-1:0] win3(input int a, input int b, input int c);
    logic [31:0] x, y, z;
    x = 32'(a);
    y = 32'(b);
    z = 32'(c);
    return {x, y, z};
  endfunction

  // One clock: drive inputs, check the combinational pop, advance model, check outputs.
  task automatic step(input bit en, input logic [BS-1:0] rm, input bit rdy);
    bit want_pop;
    bit line_end;
    @(negedge clk);
    Enable   = en;
    ReadyM   = rm;
    WinReady = rdy;
    FifoData = next_sample;
    #1;
    want_pop = en && (rm != '0) && (!want_valid || rdy);
    chk("pop", TW'(Pop), TW'(want_pop));
    if (want_valid && !rdy && (want_stall != 16'hFFFF)) want_stall = want_stall + 16'd1;
    @(posedge clk);
    #1;
    if (want_pop) begin
      line_q.push_back(next_sample);
      next_sample = next_sample + 32'd1;
      line_end = (col == LL - 1);
      col = line_end ? 0 : col + 1;
      if (line_q.size() >= WS) begin
        want_valid = 1'b1;
        want_last  = line_end;
        for (int k = 0; k < WS; k++)
          want_data[(WS-1-k)*DW +: DW] = line_q[line_q.size() - WS + k];
      end else if (rdy) begin
        want_valid = 1'b0;
      end
      if (line_end) line_q.delete();
    end else if (rdy) begin
      want_valid = 1'b0;
    end
    chk("win_valid", TW'(WinValid), TW'(want_valid));
    if (want_valid) begin
      chk("win_data", WinData, want_data);
      chk("win_last", TW'(WinLast), TW'(want_last));
    end
`ifdef CONV_READER_STATS_EN
    chk("stall_cnt", TW'(StallCnt), TW'(want_stall));
`endif
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    aclr   = 1'b0;
    Enable = 1'b0;
    #1;
    chk("rst_valid", TW'(WinValid), '0);
    chk("rst_data", WinData, '0);
    chk("rst_last", TW'(WinLast), '0);
    chk("rst_pop", TW'(Pop), '0);
`ifdef CONV_READER_STATS_EN
    chk("rst_stall", TW'(StallCnt), '0);
`endif
    @(negedge clk);
    aclr = 1'b1;
    line_q.delete();
    col        = 0;
    want_valid = 1'b0;
    want_last  = 1'b0;
    want_stall = '0;
  endtask

  initial begin
    int n_win;
    logic [BS-1:0] rm;

    // Streaming across a line boundary
    reset_pulse();
    n_win = 0;
    for (int i = 0; i < 19; i++) begin
      step(1'b1, '1, 1'b1);
      if (i < 16 && WinValid) n_win++;
      if (i == 2) chk("first_win", WinData, win3(0, 1, 2));
      if (i == 15) begin
        chk("line_last_flag", TW'(WinLast), TW'(1));
        chk("line_last_win", WinData, win3(13, 14, 15));
      end
      if (i == 16 || i == 17) chk("line_gap", TW'(WinValid), '0);
      if (i == 18) chk("next_line_first", WinData, win3(16, 17, 18));
    end
    chk("win_per_line", TW'(n_win), TW'(14));

    // Backpressure on window {3,4,5}
    reset_pulse();
    next_sample = '0;
    for (int i = 0; i < 6; i++) step(1'b1, '1, 1'b1);
    chk("bp_win", WinData, win3(3, 4, 5));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, '1, 1'b0);
      chk("bp_hold", WinData, win3(3, 4, 5));
    end
`ifdef CONV_READER_STATS_EN
    chk("bp_stall5", TW'(StallCnt), TW'(5));
`endif
    step(1'b1, '1, 1'b1);
    chk("bp_release", WinData, win3(4, 5, 6));

    // FIFO drain after sample 7, refill with 8
    step(1'b1, '1, 1'b1);
    chk("drain_last", WinData, win3(5, 6, 7));
    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b1);
    chk("drain_valid", TW'(WinValid), '0);
    step(1'b1, '1, 1'b1);
    chk("refill_win", WinData, win3(6, 7, 8));

    // Enable gap at column 10
    step(1'b1, '1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, '1, 1'b1);
    chk("gap_last_flag", TW'(WinLast), TW'(1));
    chk("gap_last_win", WinData, win3(13, 14, 15));

    // Mid-line reset at column 6
    for (int i = 0; i < 6; i++) step(1'b1, '1, 1'b1);
    reset_pulse();
    step(1'b1, '1, 1'b1);
    step(1'b1, '1, 1'b1);
    chk("post_rst_fill", TW'(WinValid), '0);
    step(1'b1, '1, 1'b1);
    chk("post_rst_first", WinData, win3(22, 23, 24));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) reset_pulse();
      rm = ($urandom_range(0, 3) == 0) ? '0 : BS'($urandom_range(1, 65535));
      step($urandom_range(0, 9) != 0, rm, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
